// File: rtl/sram_arb_pkg.sv
// Shared types for the two-master SRAM arbiter: FSM state encoding and master indices.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD0  = 2'd1,
        RD1  = 2'd2,
        WR1  = 2'd3
    } arb_state_e;

    localparam logic M_IFU = 1'b0;
    localparam logic M_LSU = 1'b1;

endpackage

// File: rtl/sram_arb_b_buffer.sv
// Single-entry holding register for the SRAM write response, which the SRAM
// presents for one cycle only and which the LSU may not accept immediately.
module sram_arb_b_buffer (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic s_bvalid,
    input  logic s_bresp,
    output logic s_bready,
    output logic m_bvalid,
    output logic m_bresp,
    input  logic m_bready
);

    logic bvalid_q, bvalid_d;
    logic bresp_q, bresp_d;

    always_comb begin
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        s_bready = en & ~bvalid_q;
        if (s_bready && s_bvalid) begin
            bvalid_d = 1'b1;
            bresp_d  = s_bresp;
        end else if (bvalid_q && m_bready) begin
            bvalid_d = 1'b0;
        end
        m_bvalid = bvalid_q;
        m_bresp  = bresp_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bvalid_q <= 1'b0;
            bresp_q  <= 1'b0;
        end else begin
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-master (IFU read-only, LSU read/write) AXI-lite style arbiter in front of
// the shared SRAM; one master owns the SRAM from grant until its response handshake.
//
// state | meaning
// IDLE  | no owner; arbitrate registered requests, all valids/readys low
// RD0   | IFU owns the SRAM for one read (AR then R)
// RD1   | LSU owns the SRAM for one read (AR then R)
// WR1   | LSU owns the SRAM for one write (AW/W then buffered B)
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [ADDR_W-1:0]   m0_araddr,
    input  logic                m0_arvalid,
    output logic                m0_arready,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_rresp,
    output logic                m0_rvalid,
    input  logic                m0_rready,

    input  logic [ADDR_W-1:0]   m1_araddr,
    input  logic                m1_arvalid,
    output logic                m1_arready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_rresp,
    output logic                m1_rvalid,
    input  logic                m1_rready,
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic                m1_awvalid,
    output logic                m1_awready,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic                m1_wvalid,
    output logic                m1_wready,
    output logic                m1_bresp,
    output logic                m1_bvalid,
    input  logic                m1_bready,

    output logic [ADDR_W-1:0]   s_araddr,
    output logic                s_arvalid,
    input  logic                s_arready,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic                s_rresp,
    input  logic                s_rvalid,
    output logic                s_rready,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_wvalid,
    input  logic                s_wready,
    input  logic                s_bresp,
    input  logic                s_bvalid,
    output logic                s_bready
);

    arb_state_e state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic       ar_done_q, ar_done_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;
    logic       m1_req;
    logic       rd_sel;
    logic       rd_arvalid;
    logic       rd_rready;
    logic       b_en;
    arb_state_e m1_state;

    assign s_awaddr = m1_awaddr;
    assign s_wdata  = m1_wdata;
    assign s_wstrb  = m1_wstrb;
    // Data may mirror the SRAM for both masters; the per-master rvalid gates it.
    assign m0_rdata = s_rdata;
    assign m0_rresp = s_rresp;
    assign m1_rdata = s_rdata;
    assign m1_rresp = s_rresp;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        ar_done_d    = ar_done_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        m0_arready   = 1'b0;
        m0_rvalid    = 1'b0;
        m1_arready   = 1'b0;
        m1_rvalid    = 1'b0;
        m1_awready   = 1'b0;
        m1_wready    = 1'b0;
        s_araddr     = m0_araddr;
        s_arvalid    = 1'b0;
        s_rready     = 1'b0;
        s_awvalid    = 1'b0;
        s_wvalid     = 1'b0;
        b_en         = 1'b0;
        m1_req       = m1_awvalid | m1_arvalid;
        m1_state     = m1_awvalid ? WR1 : RD1;
        rd_sel       = (state_q == RD1);
        rd_arvalid   = rd_sel ? m1_arvalid : m0_arvalid;
        rd_rready    = rd_sel ? m1_rready : m0_rready;

        case (state_q)
            IDLE: begin
                if (m0_arvalid && m1_req) begin
                    if (ROUND_ROBIN && last_grant_q == M_LSU) begin
                        state_d      = RD0;
                        last_grant_d = M_IFU;
                    end else begin
                        state_d      = m1_state;
                        last_grant_d = M_LSU;
                    end
                end else if (m1_req) begin
                    state_d      = m1_state;
                    last_grant_d = M_LSU;
                end else if (m0_arvalid) begin
                    state_d      = RD0;
                    last_grant_d = M_IFU;
                end
            end
            RD0, RD1: begin
                s_araddr  = rd_sel ? m1_araddr : m0_araddr;
                s_arvalid = rd_arvalid & ~ar_done_q;
                s_rready  = rd_rready;
                if (rd_sel) begin
                    m1_arready = s_arready & ~ar_done_q;
                    m1_rvalid  = s_rvalid;
                end else begin
                    m0_arready = s_arready & ~ar_done_q;
                    m0_rvalid  = s_rvalid;
                end
                if (s_arvalid && s_arready) ar_done_d = 1'b1;
                if (s_rvalid && rd_rready) begin
                    state_d   = IDLE;
                    ar_done_d = 1'b0;
                end else if (!ar_done_q && !rd_arvalid) begin
                    // Master withdrew before the SRAM saw the address.
                    state_d = IDLE;
                end
            end
            WR1: begin
                s_awvalid  = m1_awvalid & ~aw_done_q;
                m1_awready = s_awready & ~aw_done_q;
                s_wvalid   = m1_wvalid & ~w_done_q;
                m1_wready  = s_wready & ~w_done_q;
                b_en       = 1'b1;
                if (s_awvalid && s_awready) aw_done_d = 1'b1;
                if (s_wvalid && s_wready)   w_done_d  = 1'b1;
                if (m1_bvalid && m1_bready) begin
                    state_d   = IDLE;
                    ar_done_d = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    sram_arb_b_buffer u_b_buffer (
        .clk      (clk),
        .rst      (rst),
        .en       (b_en),
        .s_bvalid (s_bvalid),
        .s_bresp  (s_bresp),
        .s_bready (s_bready),
        .m_bvalid (m1_bvalid),
        .m_bresp  (m1_bresp),
        .m_bready (m1_bready)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= M_LSU;
            ar_done_q    <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            ar_done_q    <= ar_done_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: dut uses round-robin, dut_fp fixed priority;
// both see the same master stimulus, each has its own zero-delay SRAM model.
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] m0_araddr = '0, m1_araddr = '0, m1_awaddr = '0, m1_wdata = '0;
    logic        m0_arvalid = 0, m0_rready = 0, m1_arvalid = 0, m1_rready = 0;
    logic        m1_awvalid = 0, m1_wvalid = 0, m1_bready = 0;
    logic [3:0]  m1_wstrb = '0;
    logic [31:0] rdata_a = '0;

    logic [31:0] m0_rdata, m1_rdata, s_araddr, s_rdata, s_awaddr, s_wdata;
    logic        m0_arready, m0_rresp, m0_rvalid, m1_arready, m1_rresp, m1_rvalid;
    logic        m1_awready, m1_wready, m1_bresp, m1_bvalid;
    logic        s_arvalid, s_arready, s_rresp, s_rvalid, s_rready, s_awvalid, s_awready;
    logic        s_wvalid, s_wready, s_bresp, s_bvalid, s_bready;
    logic [3:0]  s_wstrb;

    logic [31:0] b_m0_rdata, b_m1_rdata, b_s_araddr, b_s_rdata, b_s_awaddr, b_s_wdata;
    logic        b_m0_arready, b_m0_rresp, b_m0_rvalid, b_m1_arready, b_m1_rresp, b_m1_rvalid;
    logic        b_m1_awready, b_m1_wready, b_m1_bresp, b_m1_bvalid;
    logic        b_s_arvalid, b_s_arready, b_s_rresp, b_s_rvalid, b_s_rready, b_s_awvalid;
    logic        b_s_awready, b_s_wvalid, b_s_wready, b_s_bresp, b_s_bvalid, b_s_bready;
    logic [3:0]  b_s_wstrb;

    sram_arbiter #(.ADDR_W(32), .DATA_W(32), .ROUND_ROBIN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
        .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
    );

    sram_arbiter #(.ADDR_W(32), .DATA_W(32), .ROUND_ROBIN(1'b0)) dut_fp (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(b_m0_arready),
        .m0_rdata(b_m0_rdata), .m0_rresp(b_m0_rresp), .m0_rvalid(b_m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(b_m1_arready),
        .m1_rdata(b_m1_rdata), .m1_rresp(b_m1_rresp), .m1_rvalid(b_m1_rvalid), .m1_rready(m1_rready),
        .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(b_m1_awready),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(b_m1_wready),
        .m1_bresp(b_m1_bresp), .m1_bvalid(b_m1_bvalid), .m1_bready(m1_bready),
        .s_araddr(b_s_araddr), .s_arvalid(b_s_arvalid), .s_arready(b_s_arready),
        .s_rdata(b_s_rdata), .s_rresp(b_s_rresp), .s_rvalid(b_s_rvalid), .s_rready(b_s_rready),
        .s_awaddr(b_s_awaddr), .s_awvalid(b_s_awvalid), .s_awready(b_s_awready),
        .s_wdata(b_s_wdata), .s_wstrb(b_s_wstrb), .s_wvalid(b_s_wvalid), .s_wready(b_s_wready),
        .s_bresp(b_s_bresp), .s_bvalid(b_s_bvalid), .s_bready(b_s_bready)
    );

    // Zero-delay SRAM models: R one cycle after AR, one-cycle B after AW and W.
    logic a_rpend, a_aws, a_ws, a_bv, b_rpend;
    logic a_aws_n, a_ws_n;
    int   ar_cnt = 0, aw_cnt = 0, w_cnt = 0;

    assign s_arready = 1'b1;
    assign s_rvalid  = a_rpend;
    assign s_rdata   = rdata_a;
    assign s_rresp   = 1'b0;
    assign s_awready = 1'b1;
    assign s_wready  = 1'b1;
    assign s_bvalid  = a_bv;
    assign s_bresp   = 1'b1;
    assign a_aws_n   = a_aws | (s_awvalid & s_awready);
    assign a_ws_n    = a_ws | (s_wvalid & s_wready);

    always @(posedge clk) begin
        if (rst) a_rpend <= 1'b0;
        else if (s_rvalid && s_rready) a_rpend <= 1'b0;
        else if (s_arvalid && s_arready) a_rpend <= 1'b1;
        if (rst) begin
            a_aws <= 1'b0; a_ws <= 1'b0; a_bv <= 1'b0;
        end else if (a_aws_n && a_ws_n) begin
            a_aws <= 1'b0; a_ws <= 1'b0; a_bv <= 1'b1;
        end else begin
            a_aws <= a_aws_n; a_ws <= a_ws_n; a_bv <= 1'b0;
        end
        if (s_arvalid && s_arready) ar_cnt <= ar_cnt + 1;
        if (s_awvalid && s_awready) aw_cnt <= aw_cnt + 1;
        if (s_wvalid && s_wready)   w_cnt  <= w_cnt + 1;
    end

    assign b_s_arready = 1'b1;
    assign b_s_rvalid  = b_rpend;
    assign b_s_rdata   = rdata_a;
    assign b_s_rresp   = 1'b0;
    assign b_s_awready = 1'b1;
    assign b_s_wready  = 1'b1;
    assign b_s_bvalid  = 1'b0;
    assign b_s_bresp   = 1'b0;

    always @(posedge clk) begin
        if (rst) b_rpend <= 1'b0;
        else if (b_s_rvalid && b_s_rready) b_rpend <= 1'b0;
        else if (b_s_arvalid && b_s_arready) b_rpend <= 1'b1;
    end

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] a_outs();
        return {m0_arready, m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready,
                m1_bvalid, s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready};
    endfunction

    function automatic logic sig(input int id);
        case (id)
            0: return m0_arready;
            1: return m1_arready;
            2: return m0_rvalid;
            3: return m1_rvalid;
            4: return m1_awready;
            5: return m1_bvalid;
            6: return b_m0_rvalid;
            7: return b_m1_rvalid;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_hi(input int id, input string tag, output int n);
        n = 0;
        while (!sig(id) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(sig(id)), 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m0_arvalid = 0; m1_arvalid = 0; m1_awvalid = 0; m1_wvalid = 0;
        m0_rready = 0; m1_rready = 0; m1_bready = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic rd(input logic m, input logic [31:0] addr, input logic [31:0] data,
                      input string tag);
        int n_ar, n_r;
        rdata_a = data;
        m0_rready = 1'b1;
        m1_rready = 1'b1;
        if (m) begin m1_araddr = addr; m1_arvalid = 1'b1; end
        else   begin m0_araddr = addr; m0_arvalid = 1'b1; end
        wait_hi(m ? 1 : 0, {tag, " arready"}, n_ar);
        check({tag, " grant_lat"}, 64'(n_ar), 64'd1);
        check({tag, " s_araddr"}, 64'(s_araddr), 64'(addr));
        @(negedge clk);
        m0_arvalid = 1'b0;
        m1_arvalid = 1'b0;
        wait_hi(m ? 3 : 2, {tag, " rvalid"}, n_r);
        check({tag, " r_lat"}, 64'(n_r), 64'd0);
        check({tag, " rdata"}, 64'(m ? m1_rdata : m0_rdata), 64'(data));
        check({tag, " other_rvalid"}, 64'(m ? m0_rvalid : m1_rvalid), 64'd0);
        @(negedge clk);
        check({tag, " idle"}, 64'(dut.state_q), 64'(IDLE));
    endtask

    // Both masters request together; the loser withdraws once the winner is known.
    task automatic contend(input bit fp, input logic exp_m, input string tag);
        logic w0, w1;
        int   n;
        m0_araddr = 32'h8000_1000; m1_araddr = 32'h8000_2000;
        m0_arvalid = 1'b1; m1_arvalid = 1'b1; m0_rready = 1'b1; m1_rready = 1'b1;
        @(negedge clk);
        w0 = fp ? b_m0_arready : m0_arready;
        w1 = fp ? b_m1_arready : m1_arready;
        check(tag, 64'({w1, w0}), exp_m ? 64'd2 : 64'd1);
        if (exp_m) m0_arvalid = 1'b0;
        else       m1_arvalid = 1'b0;
        @(negedge clk);
        m0_arvalid = 1'b0;
        m1_arvalid = 1'b0;
        wait_hi(fp ? (exp_m ? 7 : 6) : (exp_m ? 3 : 2), {tag, " rvalid"}, n);
        @(negedge clk);
    endtask

    initial begin
        int n, aw0, w0, c0;
        logic hold_ok;

        do_reset();
        check("reset outs", 64'(a_outs()), 64'd0);
        check("reset state", 64'(dut.state_q), 64'(IDLE));
        @(negedge clk);
        check("idle outs", 64'(a_outs()), 64'd0);

        rd(1'b0, 32'h8000_0000, 32'h1234_5678, "m0_read");

        do_reset();
        contend(1'b0, 1'b0, "rr grant1");
        contend(1'b0, 1'b1, "rr grant2");
        contend(1'b0, 1'b0, "rr grant3");
        contend(1'b0, 1'b1, "rr grant4");

        do_reset();
        for (int i = 0; i < 4; i++) contend(1'b1, 1'b1, $sformatf("fp grant%0d", i + 1));

        do_reset();
        aw0 = aw_cnt; w0 = w_cnt;
        m1_awaddr = 32'h8000_0100; m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'hF;
        m1_awvalid = 1'b1; m1_wvalid = 1'b1; m1_bready = 1'b0;
        wait_hi(4, "wr awready", n);
        check("wr wready", 64'(m1_wready), 64'd1);
        check("wr s_awaddr", 64'(s_awaddr), 64'h8000_0100);
        check("wr s_wdata", 64'(s_wdata), 64'hDEAD_BEEF);
        check("wr s_wstrb", 64'(s_wstrb), 64'hF);
        @(negedge clk);
        m1_awvalid = 1'b0; m1_wvalid = 1'b0;
        wait_hi(5, "wr bvalid", n);
        hold_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (m1_bvalid !== 1'b1 || dut.state_q !== WR1 || s_bready !== 1'b0) hold_ok = 1'b0;
            @(negedge clk);
        end
        check("wr bvalid hold", 64'(hold_ok), 64'd1);
        check("wr bresp", 64'(m1_bresp), 64'd1);
        m1_bready = 1'b1;
        @(negedge clk);
        m1_bready = 1'b0;
        check("wr idle", 64'(dut.state_q), 64'(IDLE));
        check("wr bvalid clr", 64'(m1_bvalid), 64'd0);
        check("wr aw count", 64'(aw_cnt - aw0), 64'd1);
        check("wr w count", 64'(w_cnt - w0), 64'd1);

        do_reset();
        c0 = ar_cnt;
        m0_araddr = 32'h8000_0040; m0_arvalid = 1'b1;
        @(negedge clk);
        check("abandon granted", 64'(dut.state_q), 64'(RD0));
        m0_arvalid = 1'b0;
        #1;
        check("abandon s_arvalid", 64'(s_arvalid), 64'd0);
        @(negedge clk);
        check("abandon idle", 64'(dut.state_q), 64'(IDLE));
        check("abandon no ar", 64'(ar_cnt - c0), 64'd0);
        rd(1'b1, 32'h8000_0200, 32'hCAFE_F00D, "m1_read");

        do_reset();
        rdata_a = 32'h5555_AAAA;
        m1_araddr = 32'h8000_0300; m1_arvalid = 1'b1; m1_rready = 1'b0;
        wait_hi(1, "rst arready", n);
        @(negedge clk);
        m1_arvalid = 1'b0;
        check("rst pre state", 64'(dut.state_q), 64'(RD1));
        check("rst pre rvalid", 64'(m1_rvalid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst state", 64'(dut.state_q), 64'(IDLE));
        check("rst outs", 64'(a_outs()), 64'd0);
        rst = 1'b0;
        rd(1'b0, 32'h8000_0004, 32'h0BAD_C0DE, "m0_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-master to one-slave AXI-lite style arbiter in front of the shared SRAM.
- Master 0 is the IFU (read-only). Master 1 is the LSU (read and write).
- Serialises transactions so exactly one master owns the SRAM at a time, and holds the grant from address acceptance until the response handshake.
- Buffers the SRAM's single-cycle write response until the LSU accepts it.

Parameters:
ADDR_W, 32, address width of all address buses
DATA_W, 32, data width; strobe width is DATA_W/8
ROUND_ROBIN, 1, 1 = alternate on contention; 0 = fixed priority, master 1 (LSU) wins

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
m0_araddr/m0_arvalid input ADDR_W/1; m0_arready output 1  IFU read address
m0_rdata/m0_rresp/m0_rvalid output DATA_W/1/1; m0_rready input 1  IFU read data
m1_araddr/m1_arvalid input ADDR_W/1; m1_arready output 1  LSU read address
m1_rdata/m1_rresp/m1_rvalid output DATA_W/1/1; m1_rready input 1  LSU read data
m1_awaddr/m1_awvalid input ADDR_W/1; m1_awready output 1  LSU write address
m1_wdata/m1_wstrb/m1_wvalid input DATA_W/DATA_W/8/1; m1_wready output 1  LSU write data
m1_bresp/m1_bvalid output 1/1; m1_bready input 1  LSU write response
s_araddr/s_arvalid output; s_arready input  SRAM read address
s_rdata/s_rresp/s_rvalid input; s_rready output  SRAM read data
s_awaddr/s_awvalid output; s_awready input  SRAM write address
s_wdata/s_wstrb/s_wvalid output; s_wready input  SRAM write data
s_bresp/s_bvalid input; s_bready output  SRAM write response

Behaviour:
- Reset:
  - state=IDLE; flags ar_done, aw_done, w_done, bvalid_q cleared; bresp_q=0.
  - last_grant=1, so the first contended grant goes to m0.
  - Every valid/ready output is 0.
- States (2-bit): IDLE, RD0, RD1, WR1.
- IDLE:
  - All master readys and slave valids are 0. The decision is registered, so arbitration costs 1 cycle.
  - m1_awvalid takes precedence over m1_arvalid (LSU never issues both; if it does, the write wins) -> WR1.
  - m0_arvalid alone -> RD0. m1_arvalid alone -> RD1.
  - m0 and m1 both requesting:
    - ROUND_ROBIN=1: grant the master != last_grant.
    - ROUND_ROBIN=0: grant m1.
  - last_grant is updated on every grant.
- RDx:
  - s_araddr = mx_araddr.
  - s_arvalid = mx_arvalid & !ar_done; mx_arready = s_arready & !ar_done.
  - ar_done is set on AR handshake, so only one AR is issued per grant.
  - R channel passes through: mx_rvalid = s_rvalid; s_rready = mx_rready; data/resp are forwarded.
  - On R handshake -> IDLE, ar_done cleared.
  - If mx_arvalid drops before the AR handshake -> IDLE (abandoned request, no SRAM access).
- WR1:
  - AW and W forwarded independently with the same gating via aw_done/w_done. Simultaneous AW+W in one cycle is allowed.
  - s_bready=1 while !bvalid_q.
  - s_bvalid sets bvalid_q and captures bresp_q. m1_bvalid=bvalid_q; m1_bresp=bresp_q.
  - On m1 B handshake -> IDLE, all flags cleared.
  - Back-to-back: m1_bready held high with bvalid_q set -> IDLE the next cycle; a new grant follows one cycle later.
- Non-granted master:
  - arready/rvalid/awready/wready/bvalid are 0.
  - rdata may mirror s_rdata, since the valids gate it.
- Slave valids are 0 outside the matching state. No slave valid is ever asserted combinationally from IDLE.
- No timeout; a slave that never responds holds the grant indefinitely.
- Reset mid-transaction: return to IDLE immediately; the in-flight transaction is dropped. Masters share rst.
- Minimum read latency IDLE->R handshake is 3 cycles with a zero-delay SRAM: grant, AR, R.

Decomposition:
- Package sram_arb_pkg: state enum (IDLE/RD0/RD1/WR1), master index constants M_IFU=0 and M_LSU=1.
- One sub-module, sram_arb_b_buffer: a single-entry bvalid/bresp holding register with its ready/valid logic.
- Grant logic stays inline.

Test Plan:
- Reset then idle: all valid/ready outputs 0. m0 read 0x80000000, SRAM returns 0x12345678 -> m0_rvalid with that data; m1 sees no rvalid.
- m0 and m1 arvalid asserted in the same cycle, ROUND_ROBIN=1, repeated 4 times -> grants m0, m1, m0, m1.
- Same stimulus with ROUND_ROBIN=0 -> m1 granted every time.
- LSU write 0xDEADBEEF, wstrb 0xF, to 0x80000100 with m1_bready held low 5 cycles -> m1_bvalid stays 1 through the hold, exactly one SRAM write occurs, and IDLE is entered after bready rises.
- m0_arvalid pulsed for 1 cycle only (dropped during grant cycle) -> no s_arvalid, return to IDLE; a subsequent m1 read is served normally.
- rst asserted while in RD1 with s_rvalid pending -> next cycle state IDLE and all outputs 0; a following m0 read completes with correct data.
